// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - single-clock RAM-based FIFO with registered read data and count-decoded flags
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_rd_data;

    logic w_empty;
    logic w_full;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);
    assign w_wr_acc = i_wr_en && !w_full;
    assign w_rd_acc = i_rd_en && !w_empty;

    // Storage has no reset so it can map onto a plain RAM; stale words are unreachable after reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc && !i_rst) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // A read while empty returns zero; a same-edge write is never bypassed.
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end else if (i_rd_en) begin
                r_rd_data <= '0;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_empty   = w_empty;
    assign o_full    = w_full;

endmodule

// File: tb/tb_fifo_ram.sv
// tb/tb_fifo_ram.sv - scoreboard testbench for fifo_ram
module tb_fifo_ram;

    localparam int WIDTH = 8;
    localparam int DEPTH = 256;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic [WIDTH-1:0] i_wr_data = '0;
    logic             i_wr_en = 1'b0;
    logic             i_rd_en = 1'b0;
    logic [WIDTH-1:0] o_rd_data;
    logic             o_empty;
    logic             o_full;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] last_rd = '0;

    fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_data (i_wr_data),
        .i_wr_en   (i_wr_en),
        .i_rd_en   (i_rd_en),
        .o_rd_data (o_rd_data),
        .o_empty   (o_empty),
        .o_full    (o_full)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, update the model from pre-edge state, then check after the edge.
    task automatic cycle(input logic wr, input logic [WIDTH-1:0] data, input logic rd);
        bit full_pre;
        bit empty_pre;
        bit wr_acc;
        bit rd_acc;
        logic [WIDTH-1:0] exp;
        full_pre  = (model_q.size() == DEPTH);
        empty_pre = (model_q.size() == 0);
        wr_acc    = wr && !full_pre;
        rd_acc    = rd && !empty_pre;
        i_wr_en   = wr;
        i_wr_data = data;
        i_rd_en   = rd;
        if (rd) exp_q.push_back(rd_acc ? model_q[0] : '0);
        if (rd_acc) void'(model_q.pop_front());
        if (wr_acc) model_q.push_back(data);
        @(posedge i_clk);
        #1;
        if (rd) begin
            exp = exp_q.pop_front();
            check("rd_data", o_rd_data, exp);
            last_rd = exp;
        end else begin
            check("rd_hold", o_rd_data, last_rd);
        end
        check("empty", o_empty, model_q.size() == 0);
        check("full", o_full, model_q.size() == DEPTH);
    endtask

    initial begin
        #2;
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_rd", o_rd_data, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        cycle(1, 8'hAA, 0);
        cycle(0, 8'h00, 1);
        check("single_aa", o_rd_data, 8'hAA);
        check("single_empty", o_empty, 1);

        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0);
        check("fill_full", o_full, 1);
        cycle(1, 8'h55, 0);
        check("overfill_full", o_full, 1);

        cycle(0, 8'h00, 1);
        check("first_rd", o_rd_data, 8'h00);
        check("first_rd_full", o_full, 0);

        for (int i = 1; i <= DEPTH; i++) begin
            cycle(0, 8'h00, 1);
            check("drain", o_rd_data, (i < DEPTH) ? 8'(i) : 8'h00);
        end
        check("drain_empty", o_empty, 1);

        cycle(0, 8'h00, 1);
        check("empty_rd", o_rd_data, 8'h00);
        cycle(1, 8'h3C, 1);
        check("wr_rd_empty_nobypass", o_rd_data, 8'h00);
        cycle(0, 8'h00, 1);
        check("after_empty_rd", o_rd_data, 8'h3C);

        for (int i = 0; i < DEPTH / 2; i++) cycle(1, 8'($urandom_range(0, 255)), 0);
        for (int i = 0; i < 600; i++) begin
            cycle(1, 8'($urandom_range(0, 255)), 1);
            check("half_count", model_q.size(), DEPTH / 2);
            check("half_noflag", {o_empty, o_full}, 2'b00);
        end

        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        check("async_empty", o_empty, 1);
        check("async_full", o_full, 0);
        check("async_rd", o_rd_data, 0);
        model_q.delete();
        exp_q.delete();
        last_rd = '0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        cycle(1, 8'h81, 0);
        cycle(1, 8'h7E, 1);
        cycle(0, 8'h00, 1);
        check("post_rst_order", o_rd_data, 8'h7E);
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
